// File: rtl/ddr_rx.sv
// HDR-DDR receive deserializer: shifts SDA in on every SCL edge and reassembles
// preamble, data, parity, token and CRC fields, checking each against its reference.
module ddr_rx (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_ddrccc_rx_en,
  input  logic [3:0] i_ddrccc_rx_mode,
  input  logic       i_sclgen_scl_pos_edge,
  input  logic       i_sclgen_scl_neg_edge,
  input  logic       i_sdahnd_rx_sda,
  input  logic [4:0] i_crc_crc_value,
  output logic       o_ddrccc_rx_mode_done,
  output logic [1:0] o_rx_preamble,
  output logic [7:0] o_regf_rx_parallel_data,
  output logic       o_regf_wr_en,
  output logic [7:0] o_crc_parallel_data,
  output logic       o_crc_data_valid,
  output logic       o_crc_last_byte,
  output logic       o_parity_err,
  output logic       o_token_err,
  output logic       o_crc_err
);

  localparam logic [3:0] MODE_PRE   = 4'b0000;
  localparam logic [3:0] MODE_DATA  = 4'b0111;
  localparam logic [3:0] MODE_PAR   = 4'b0100;
  localparam logic [3:0] MODE_TOK   = 4'b1100;
  localparam logic [3:0] MODE_CRC   = 4'b1101;
  localparam logic [3:0] TOKEN_WORD = 4'b1100;

  function automatic logic is_field(input logic [3:0] mode);
    case (mode)
      MODE_PRE, MODE_DATA, MODE_PAR, MODE_TOK, MODE_CRC: is_field = 1'b1;
      default:                                           is_field = 1'b0;
    endcase
  endfunction

  // Index of the final bit of each field (field length minus one).
  function automatic logic [2:0] last_idx(input logic [3:0] mode);
    case (mode)
      MODE_PRE:  last_idx = 3'd1;
      MODE_DATA: last_idx = 3'd7;
      MODE_PAR:  last_idx = 3'd1;
      MODE_TOK:  last_idx = 3'd3;
      MODE_CRC:  last_idx = 3'd4;
      default:   last_idx = 3'd7;
    endcase
  endfunction

  // Expected {P1, P0} over the two-byte word; P0 is inverted.
  function automatic logic [1:0] parity_calc(input logic [7:0] d1, input logic [7:0] d2);
    logic p1;
    logic p0;
    p1 = d1[7] ^ d1[5] ^ d1[3] ^ d1[1] ^ d2[7] ^ d2[5] ^ d2[3] ^ d2[1];
    p0 = d1[6] ^ d1[4] ^ d1[2] ^ d1[0] ^ d2[6] ^ d2[4] ^ d2[2] ^ d2[0] ^ 1'b1;
    parity_calc = {p1, p0};
  endfunction

  logic [7:0] shift_q,     shift_d;
  logic [2:0] cnt_q,       cnt_d;
  logic [3:0] prev_mode_q, prev_mode_d;
  logic [7:0] d1_q,        d1_d;
  logic [7:0] d2_q,        d2_d;
  logic       sel_q,       sel_d;
  logic       done_q,      done_d;
  logic [1:0] pre_q,       pre_d;
  logic [7:0] rx_data_q,   rx_data_d;
  logic       wr_en_q,     wr_en_d;
  logic       crc_vld_q,   crc_vld_d;
  logic       last_byte_q, last_byte_d;
  logic       par_err_q,   par_err_d;
  logic       tok_err_q,   tok_err_d;
  logic       crc_err_q,   crc_err_d;

  logic       bit_evt;
  logic       mode_chg;
  logic       final_bit;
  logic [2:0] cnt_base;

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    prev_mode_d = i_ddrccc_rx_mode;
    d1_d        = d1_q;
    d2_d        = d2_q;
    sel_d       = sel_q;
    done_d      = 1'b0;
    pre_d       = pre_q;
    rx_data_d   = rx_data_q;
    wr_en_d     = 1'b0;
    crc_vld_d   = 1'b0;
    last_byte_d = 1'b0;
    par_err_d   = par_err_q;
    tok_err_d   = tok_err_q;
    crc_err_d   = crc_err_q;
    final_bit   = 1'b0;

    bit_evt  = i_ddrccc_rx_en & (i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge)
               & is_field(i_ddrccc_rx_mode);
    // A mode switch discards partial bits; an edge in the same cycle becomes bit 0.
    mode_chg = (i_ddrccc_rx_mode != prev_mode_q);
    cnt_base = mode_chg ? 3'd0 : cnt_q;
    cnt_d    = cnt_base;

    if (bit_evt) begin
      shift_d = {shift_q[6:0], i_sdahnd_rx_sda};
      if (cnt_base == last_idx(i_ddrccc_rx_mode)) begin
        final_bit = 1'b1;
        cnt_d     = 3'd0;
      end else begin
        cnt_d = cnt_base + 3'd1;
      end
    end

    if (final_bit) begin
      done_d = 1'b1;
      case (i_ddrccc_rx_mode)
        MODE_PRE: pre_d = shift_d[1:0];
        MODE_DATA: begin
          rx_data_d = shift_d;
          wr_en_d   = 1'b1;
          crc_vld_d = 1'b1;
          if (!sel_q) d1_d = shift_d;
          else        d2_d = shift_d;
          sel_d = ~sel_q;
        end
        MODE_PAR: begin
          if (shift_d[1:0] != parity_calc(d1_q, d2_q)) par_err_d = 1'b1;
          d1_d  = 8'h00;
          d2_d  = 8'h00;
          sel_d = 1'b0;
        end
        MODE_TOK: begin
          if (shift_d[3:0] != TOKEN_WORD) tok_err_d = 1'b1;
          last_byte_d = 1'b1;
        end
        MODE_CRC: begin
          if (shift_d[4:0] != i_crc_crc_value) crc_err_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (!i_ddrccc_rx_en) begin
      cnt_d       = 3'd0;
      done_d      = 1'b0;
      wr_en_d     = 1'b0;
      crc_vld_d   = 1'b0;
      last_byte_d = 1'b0;
      sel_d       = 1'b0;
      d1_d        = 8'h00;
      d2_d        = 8'h00;
      par_err_d   = 1'b0;
      tok_err_d   = 1'b0;
      crc_err_d   = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      shift_q     <= 8'h00;
      cnt_q       <= 3'd0;
      prev_mode_q <= 4'h0;
      d1_q        <= 8'h00;
      d2_q        <= 8'h00;
      sel_q       <= 1'b0;
      done_q      <= 1'b0;
      pre_q       <= 2'b00;
      rx_data_q   <= 8'h00;
      wr_en_q     <= 1'b0;
      crc_vld_q   <= 1'b0;
      last_byte_q <= 1'b0;
      par_err_q   <= 1'b0;
      tok_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      prev_mode_q <= prev_mode_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      sel_q       <= sel_d;
      done_q      <= done_d;
      pre_q       <= pre_d;
      rx_data_q   <= rx_data_d;
      wr_en_q     <= wr_en_d;
      crc_vld_q   <= crc_vld_d;
      last_byte_q <= last_byte_d;
      par_err_q   <= par_err_d;
      tok_err_q   <= tok_err_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign o_ddrccc_rx_mode_done   = done_q;
  assign o_rx_preamble           = pre_q;
  assign o_regf_rx_parallel_data = rx_data_q;
  assign o_regf_wr_en            = wr_en_q;
  assign o_crc_parallel_data     = rx_data_q;
  assign o_crc_data_valid        = crc_vld_q;
  assign o_crc_last_byte         = last_byte_q;
  assign o_parity_err            = par_err_q;
  assign o_token_err             = tok_err_q;
  assign o_crc_err               = crc_err_q;

endmodule
